// File: rtl/noise_window_ctrl.sv
// -----------------------------------------------------------------------------
// noise_window_ctrl
//   Windowed scheduler and threshold manager for the QRS noise-detection path.
//   It takes D1-scale wavelet magnitudes over a valid/ready handshake. The first
//   window after reset (when no host value was loaded) calibrates the noise
//   threshold tn from the window peak. After that, each fixed-length window
//   counts the rising crossings of tn ("bursts"), adapts tn once per window,
//   and drives the hysteretic select flag for the scale-selection mux.
//
// Ports
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   enable        in   1   run request (level)
//   sample_valid  in   1   d1 valid
//   sample_ready  out  1   block accepts d1 this cycle (CALIB/RUN)
//   d1            in   DW  sample magnitude (unsigned)
//   tn_cfg_we     in   1   load tn_cfg into tn (honoured in IDLE only)
//   tn_cfg        in   DW  host threshold value
//   tn            out  DW  current noise threshold
//   select        out  1   1 = noisy window history
//   win_done      out  1   one-cycle pulse while the closed window is applied
//   burst_count   out  8   bursts in the last closed window
//   state         out  2   0 IDLE, 1 CALIB, 2 RUN, 3 UPDATE
// -----------------------------------------------------------------------------
module noise_window_ctrl #(
    parameter int unsigned    DW       = 16,
    parameter int unsigned    WIN_LEN  = 256,
    parameter int unsigned    NOISE_HI = 9,
    parameter int unsigned    NOISE_LO = 4,
    parameter int unsigned    TN_SHIFT = 3,
    parameter logic [DW-1:0]  TN_MIN   = DW'(16),
    parameter logic [DW-1:0]  TN_INIT  = DW'(16'h0800)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic [DW-1:0] d1,
    input  logic          tn_cfg_we,
    input  logic [DW-1:0] tn_cfg,
    output logic [DW-1:0] tn,
    output logic          select,
    output logic          win_done,
    output logic [7:0]    burst_count,
    output logic [1:0]    state
);

    localparam int unsigned   SW       = $clog2(WIN_LEN);
    localparam logic [SW-1:0] LAST_IDX = SW'(WIN_LEN - 1);
    localparam logic [7:0]    HI_TH    = 8'(NOISE_HI);
    localparam logic [7:0]    LO_TH    = 8'(NOISE_LO);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALIB  = 2'd1,
        S_RUN    = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    // Registered state and outputs
    state_t        state_reg;
    logic [DW-1:0] tn_reg;
    logic          select_reg;
    logic          win_done_reg;
    logic [7:0]    burst_count_reg;
    logic          tn_loaded_reg;

    // Per-window bookkeeping
    logic [SW-1:0] samp_cnt_reg;
    logic [7:0]    cnt_reg;
    logic          prev_over_reg;
    logic [DW-1:0] peak_reg;

    // Combinational helpers
    logic          accept;
    logic          last_sample;
    logic          over;
    logic [7:0]    cnt_next;
    logic [DW-1:0] peak_next;
    logic [DW-1:0] calib_tn_next;
    logic [DW-1:0] cfg_tn_next;
    logic [DW-1:0] step;
    logic [DW:0]   up_sum;
    logic [DW-1:0] tn_up;
    logic [DW-1:0] tn_down;
    logic [DW-1:0] tn_next;
    logic          select_next;

    // tn is never allowed below TN_MIN once calibrated, loaded or adapted.
    function automatic logic [DW-1:0] clamp_min(input logic [DW-1:0] v);
        return (v < TN_MIN) ? TN_MIN : v;
    endfunction

    assign sample_ready = (state_reg == S_CALIB) || (state_reg == S_RUN);
    assign accept       = sample_valid & sample_ready;
    assign last_sample  = (samp_cnt_reg == LAST_IDX);

    always_comb begin
        // Burst detection: a rising edge of the strict over-threshold flag
        // between consecutive accepted samples; the counter saturates.
        over     = (d1 > tn_reg);
        cnt_next = cnt_reg;
        if (over && !prev_over_reg && (cnt_reg != 8'hFF)) begin
            cnt_next = cnt_reg + 8'd1;
        end

        // Peak includes the sample being accepted, so the last calibration
        // sample contributes to the threshold.
        peak_next     = (d1 > peak_reg) ? d1 : peak_reg;
        calib_tn_next = clamp_min(peak_next >> 1);
        cfg_tn_next   = clamp_min(tn_cfg);

        // Multiplicative adaptation by 1/2^TN_SHIFT. Upward step saturates at
        // all-ones; downward step cannot underflow because step <= tn.
        step    = tn_reg >> TN_SHIFT;
        up_sum  = {1'b0, tn_reg} + {1'b0, step};
        tn_up   = up_sum[DW] ? {DW{1'b1}} : up_sum[DW-1:0];
        tn_down = clamp_min(tn_reg - step);

        tn_next = tn_reg;
        if (cnt_reg > HI_TH) begin
            tn_next = tn_up;
        end else if (cnt_reg < LO_TH) begin
            tn_next = tn_down;
        end

        // Hysteresis: counts strictly between the two thresholds keep select.
        select_next = select_reg;
        if (cnt_reg >= HI_TH) begin
            select_next = 1'b1;
        end else if (cnt_reg <= LO_TH) begin
            select_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            tn_reg          <= TN_INIT;
            select_reg      <= 1'b0;
            win_done_reg    <= 1'b0;
            burst_count_reg <= 8'd0;
            tn_loaded_reg   <= 1'b0;
            samp_cnt_reg    <= '0;
            cnt_reg         <= 8'd0;
            prev_over_reg   <= 1'b0;
            peak_reg        <= '0;
        end else begin
            win_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    samp_cnt_reg  <= '0;
                    cnt_reg       <= 8'd0;
                    prev_over_reg <= 1'b0;
                    peak_reg      <= '0;
                    if (tn_cfg_we) begin
                        tn_reg        <= cfg_tn_next;
                        tn_loaded_reg <= 1'b1;
                    end
                    // A load in the same cycle as enable counts as loaded.
                    if (enable) begin
                        state_reg <= (tn_loaded_reg || tn_cfg_we) ? S_RUN : S_CALIB;
                    end
                end

                S_CALIB: begin
                    if (!enable) begin
                        // Abandon the calibration window; tn stays as it was.
                        state_reg    <= S_IDLE;
                        samp_cnt_reg <= '0;
                        peak_reg     <= '0;
                    end else if (accept) begin
                        if (last_sample) begin
                            tn_reg        <= calib_tn_next;
                            tn_loaded_reg <= 1'b1;
                            state_reg     <= S_RUN;
                            samp_cnt_reg  <= '0;
                            peak_reg      <= '0;
                        end else begin
                            samp_cnt_reg <= samp_cnt_reg + SW'(1);
                            peak_reg     <= peak_next;
                        end
                    end
                end

                S_RUN: begin
                    if (!enable) begin
                        // Partial window dropped, including any sample
                        // accepted in this same cycle.
                        state_reg     <= S_IDLE;
                        samp_cnt_reg  <= '0;
                        cnt_reg       <= 8'd0;
                        prev_over_reg <= 1'b0;
                    end else if (accept) begin
                        cnt_reg       <= cnt_next;
                        prev_over_reg <= over;
                        if (last_sample) begin
                            samp_cnt_reg <= '0;
                            state_reg    <= S_UPDATE;
                            win_done_reg <= 1'b1;
                        end else begin
                            samp_cnt_reg <= samp_cnt_reg + SW'(1);
                        end
                    end
                end

                S_UPDATE: begin
                    // win_done is high for this cycle; results land at its end.
                    burst_count_reg <= cnt_reg;
                    select_reg      <= select_next;
                    tn_reg          <= tn_next;
                    cnt_reg         <= 8'd0;
                    samp_cnt_reg    <= '0;
                    prev_over_reg   <= 1'b0;
                    state_reg       <= enable ? S_RUN : S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign tn          = tn_reg;
    assign select      = select_reg;
    assign win_done    = win_done_reg;
    assign burst_count = burst_count_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_noise_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_noise_window_ctrl
//   Randomised bench for noise_window_ctrl. Each window is built as an array of
//   samples. A window-level model computes the expected threshold, select and
//   burst count from plain arithmetic over that array, and the DUT results
//   are compared against it. Prints one line per closed window.
// -----------------------------------------------------------------------------
module tb_noise_window_ctrl;

    localparam int WIN = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [15:0] d1 = 16'd0;
    logic        tn_cfg_we = 1'b0;
    logic [15:0] tn_cfg = 16'd0;
    logic [15:0] tn;
    logic        select;
    logic        win_done;
    logic [7:0]  burst_count;
    logic [1:0]  state;

    always #5 clk = ~clk;

    noise_window_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .d1           (d1),
        .tn_cfg_we    (tn_cfg_we),
        .tn_cfg       (tn_cfg),
        .tn           (tn),
        .select       (select),
        .win_done     (win_done),
        .burst_count  (burst_count),
        .state        (state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int win_no   = 0;

    // Reference model state
    int m_tn;
    int m_sel;
    int m_burst;
    int m_loaded;

    logic [15:0] win_buf [WIN];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int count_bursts(input int thr);
        int b = 0;
        bit prev = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            bit ov = (int'(win_buf[i]) > thr);
            if (ov && !prev && b < 255) b++;
            prev = ov;
        end
        return b;
    endfunction

    task automatic model_close(input int b);
        m_burst = b;
        if (b >= 9) m_sel = 1;
        else if (b <= 4) m_sel = 0;
        if (b > 9) begin
            m_tn = m_tn + m_tn / 8;
            if (m_tn > 65535) m_tn = 65535;
        end else if (b < 4) begin
            m_tn = m_tn - m_tn / 8;
            if (m_tn < 16) m_tn = 16;
        end
    endtask

    task automatic model_reset();
        m_tn = 16'h0800; m_sel = 0; m_burst = 0; m_loaded = 0;
    endtask

    // Base samples never exceed tn; spikes (runs of 1..2) sit in separate slots.
    task automatic fill_window(input int nspikes, input int spike_val);
        for (int i = 0; i < WIN; i++) win_buf[i] = 16'($urandom_range(0, m_tn));
        if (nspikes > 0) begin
            int slot = WIN / nspikes;
            for (int j = 0; j < nspikes; j++) begin
                int pos = j * slot + int'($urandom_range(0, slot - 3));
                int len = int'($urandom_range(1, 2));
                for (int k = 0; k < len; k++)
                    win_buf[pos + k] = (spike_val != 0) ? 16'(spike_val)
                                                        : 16'($urandom_range(m_tn + 1, 65535));
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic push(input logic [15:0] v);
        int guard = 0;
        if ($urandom_range(0, 3) == 0) begin
            sample_valid = 1'b0;
            d1 = 16'($urandom);
            @(negedge clk);
        end
        sample_valid = 1'b1;
        d1 = v;
        while (sample_ready !== 1'b1 && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) check_val("ready_timeout", {31'd0, sample_ready}, 32'd1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_state"}, {30'd0, state}, 32'd0);
        check_val({tag, "_tn"}, {16'd0, tn}, 32'h0800);
        check_val({tag, "_sel"}, {31'd0, select}, 32'd0);
        check_val({tag, "_wd"}, {31'd0, win_done}, 32'd0);
        check_val({tag, "_bc"}, {24'd0, burst_count}, 32'd0);
        check_val({tag, "_rdy"}, {31'd0, sample_ready}, 32'd0);
    endtask

    task automatic check_hold(input string tag);
        check_val({tag, "_tn"}, {16'd0, tn}, m_tn);
        check_val({tag, "_sel"}, {31'd0, select}, m_sel);
        check_val({tag, "_bc"}, {24'd0, burst_count}, m_burst);
    endtask

    task automatic go_enable(input logic we, input logic [15:0] cfg, input string tag);
        enable = 1'b1;
        tn_cfg_we = we;
        tn_cfg = cfg;
        @(negedge clk);
        tn_cfg_we = 1'b0;
        if (we) begin
            m_tn = (int'(cfg) < 16) ? 16 : int'(cfg);
            m_loaded = 1;
        end
        check_val({tag, "_state"}, {30'd0, state}, (m_loaded != 0) ? 32'd2 : 32'd1);
        check_val({tag, "_tn"}, {16'd0, tn}, m_tn);
    endtask

    task automatic go_idle(input string tag);
        enable = 1'b0;
        @(negedge clk);
        check_val({tag, "_state"}, {30'd0, state}, 32'd0);
    endtask

    task automatic load_cfg(input logic [15:0] cfg, input string tag);
        tn_cfg_we = 1'b1;
        tn_cfg = cfg;
        @(negedge clk);
        tn_cfg_we = 1'b0;
        m_tn = (int'(cfg) < 16) ? 16 : int'(cfg);
        m_loaded = 1;
        check_val({tag, "_tn"}, {16'd0, tn}, m_tn);
        check_val({tag, "_state"}, {30'd0, state}, 32'd0);
    endtask

    // Calibration window over win_buf; ends directly in RUN with no win_done.
    task automatic calib_window(input string tag);
        int mx = 0;
        int early = 0;
        for (int i = 0; i < WIN; i++) if (int'(win_buf[i]) > mx) mx = int'(win_buf[i]);
        for (int i = 0; i < WIN; i++) begin
            push(win_buf[i]);
            if (win_done) early++;
        end
        m_tn = (mx / 2 < 16) ? 16 : mx / 2;
        m_loaded = 1;
        check_val({tag, "_state"}, {30'd0, state}, 32'd2);
        check_val({tag, "_tn"}, {16'd0, tn}, m_tn);
        check_val({tag, "_nodone"}, early, 0);
        $display("CALIB %s peak=%0d tn=%0d (dut %0d)", tag, mx, m_tn, tn);
    endtask

    // Full RUN window over win_buf, through UPDATE.
    task automatic run_window(input bit hold_in_update, input bit poke_cfg, input string tag);
        int exp_b = count_bursts(m_tn);
        int early = 0;
        for (int i = 0; i < WIN; i++) begin
            if (poke_cfg && i == WIN / 2) begin
                tn_cfg_we = 1'b1;
                tn_cfg = 16'h1234;
            end
            push(win_buf[i]);
            tn_cfg_we = 1'b0;
            if (i < WIN - 1 && win_done) early++;
        end
        check_val({tag, "_early"}, early, 0);
        check_val({tag, "_wd"}, {31'd0, win_done}, 32'd1);
        check_val({tag, "_upd"}, {30'd0, state}, 32'd3);
        check_val({tag, "_rdy_upd"}, {31'd0, sample_ready}, 32'd0);
        if (hold_in_update) begin
            sample_valid = 1'b1;
            d1 = 16'hFFFF;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        model_close(exp_b);
        check_hold(tag);
        check_val({tag, "_wd_off"}, {31'd0, win_done}, 32'd0);
        check_val({tag, "_next"}, {30'd0, state}, enable ? 32'd2 : 32'd0);
        win_no++;
        $display("WIN %0d %s bursts=%0d/%0d tn=%0d/%0d sel=%0d/%0d", win_no, tag,
                 burst_count, m_burst, tn, m_tn, select, m_sel);
    endtask

    // ---------------- sequence ----------------
    initial begin
        model_reset();
        #2 reset = 1'b1;
        #1 check_reset("rst0");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset("rst0_rel");

        // Ramp calibration -> tn = 255/2 = 127
        go_enable(1'b0, 16'd0, "en_calib");
        for (int i = 0; i < WIN; i++) win_buf[i] = 16'(i);
        calib_window("t1");

        // Random burst windows
        for (int w = 0; w < 4; w++) begin
            fill_window(int'($urandom_range(0, 20)), 0);
            run_window(1'b0, 1'b0, "rand");
        end

        // Drop enable mid-window (accept in the same cycle is discarded)
        fill_window(12, 0);
        for (int i = 0; i < 100; i++) push(win_buf[i]);
        sample_valid = 1'b1;
        d1 = 16'hFFFF;
        enable = 1'b0;
        @(negedge clk);
        sample_valid = 1'b0;
        check_val("t5_state", {30'd0, state}, 32'd0);
        check_val("t5_wd", {31'd0, win_done}, 32'd0);
        check_hold("t5");
        repeat (3) @(negedge clk);
        check_val("t5_wd2", {31'd0, win_done}, 32'd0);
        check_hold("t5b");

        // Host load with enable in the same cycle, then hysteresis windows
        go_enable(1'b1, 16'd100, "t2_en");
        fill_window(10, 200);
        run_window(1'b0, 1'b0, "t2");
        fill_window(6, 200);
        run_window(1'b0, 1'b0, "t3a");
        fill_window(2, 200);
        run_window(1'b1, 1'b0, "t3b_hold");
        fill_window(int'($urandom_range(3, 14)), 0);
        run_window(1'b0, 1'b1, "poke");

        // Lower clamp on load and on adaptation; re-enable skips CALIB
        go_idle("t4_idle");
        load_cfg(16'd5, "t4_min");
        go_enable(1'b0, 16'd0, "t5_reen");
        fill_window(0, 0);
        run_window(1'b0, 1'b0, "t4_floor");

        // Upper saturation
        go_idle("t4_idle2");
        go_enable(1'b1, 16'hFFF0, "t4_hi_en");
        fill_window(20, 16'hFFFF);
        run_window(1'b0, 1'b0, "t4_sat");
        fill_window(0, 0);
        enable = 1'b1;
        run_window(1'b0, 1'b0, "t4_down");

        // Asynchronous reset mid-window
        fill_window(15, 0);
        for (int i = 0; i < 50; i++) push(win_buf[i]);
        #2 reset = 1'b1;
        #1 check_reset("t6_arst");
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset("t6_rel");

        // Random calibration after reset (tn_loaded cleared -> CALIB again)
        go_enable(1'b0, 16'd0, "recal_en");
        for (int i = 0; i < WIN; i++) win_buf[i] = 16'($urandom_range(0, 20000));
        calib_window("recal");
        for (int w = 0; w < 2; w++) begin
            fill_window(int'($urandom_range(0, 24)), 0);
            run_window(w == 0, 1'b0, "rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
